// File: rtl/neureka_package.sv
// Shared types for the NEUREKA input-feature double buffer.
// Struct field widths are fixed by the package constants; the buffer's NW/DW must match them.
package neureka_package;

    localparam int unsigned NEUREKA_BLOCK_SIZE   = 32;
    localparam int unsigned NEUREKA_INFEAT_NW    = 64;
    localparam int unsigned NEUREKA_INFEAT_DW    = 8;
    localparam int unsigned NEUREKA_INFEAT_LEN_W = $clog2(NEUREKA_INFEAT_NW + 1);
    localparam int unsigned NEUREKA_INFEAT_CNT_W = $clog2(NEUREKA_INFEAT_NW);

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_ACTIVE = 2'd1,
        LD_WAIT   = 2'd2
    } state_infeat_dbuf_t;

    // "release" is a reserved word, hence release_bank
    typedef struct packed {
        logic                            goto_load;
        logic                            release_bank;
        logic [NEUREKA_INFEAT_LEN_W-1:0] load_len;
        logic [NEUREKA_INFEAT_NW-1:0]    load_mask;
        logic [NEUREKA_INFEAT_NW-1:0]    pad_implicit;
        logic [NEUREKA_INFEAT_NW-1:0]    pad_explicit;
        logic [NEUREKA_INFEAT_DW-1:0]    pad_value_lo;
        logic [NEUREKA_INFEAT_DW-1:0]    pad_value_hi;
        logic                            feat_broadcast;
    } ctrl_infeat_dbuf_t;

    typedef struct packed {
        state_infeat_dbuf_t              ld_state;
        logic [1:0]                      bank_full;
        logic                            wr_bank;
        logic                            rd_bank;
        logic [NEUREKA_INFEAT_CNT_W-1:0] vlen_cnt;
    } flags_infeat_dbuf_t;

    // A programmed length of zero means a full bank.
    function automatic logic [NEUREKA_INFEAT_LEN_W-1:0] infeat_eff_len(
        input logic [NEUREKA_INFEAT_LEN_W-1:0] len
    );
        return (len == '0) ? NEUREKA_INFEAT_LEN_W'(NEUREKA_INFEAT_NW) : len;
    endfunction

endpackage

// File: rtl/neureka_infeat_dbuf_if.sv
// Multi-lane valid/ready stream bundle; one valid/ready/data/strb per lane.
interface neureka_infeat_dbuf_if #(
    parameter int unsigned N  = 1,
    parameter int unsigned DW = 8
);
    localparam int unsigned SW = (DW + 7) / 8;

    logic [N-1:0]         valid;
    logic [N-1:0]         ready;
    logic [N-1:0][DW-1:0] data;
    logic [N-1:0][SW-1:0] strb;

    modport master (output valid, output data, output strb, input ready);
    modport slave  (input valid, input data, input strb, output ready);
endinterface

// File: rtl/neureka_infeat_dbuf_bank.sv
// One buffer bank: single write port, every word visible in parallel.
module neureka_infeat_dbuf_bank #(
    parameter int unsigned NW    = 64,
    parameter int unsigned WIDTH = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      test_mode,
    input  logic                      we,
    input  logic [$clog2(NW)-1:0]     waddr,
    input  logic [WIDTH-1:0]          wdata,
    output logic [NW-1:0][WIDTH-1:0]  rdata
);
    logic unused_test_mode;
    assign unused_test_mode = test_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (we) begin
            rdata[waddr] <= wdata;
        end
    end
endmodule

// File: rtl/neureka_infeat_dbuf.sv
// Input-feature double buffer: one bank loads from the lane stream while the other is presented.
// Optional padding muxes are built when NEUREKA_INFEAT_DBUF_PADDING_EN is defined.
module neureka_infeat_dbuf
    import neureka_package::*;
#(
    parameter int unsigned BLOCK_SIZE = NEUREKA_BLOCK_SIZE,
    parameter int unsigned NW         = 64,
    parameter int unsigned DW         = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_mode_i,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  ctrl_infeat_dbuf_t     ctrl_i,
    output flags_infeat_dbuf_t    flags_o,
    neureka_infeat_dbuf_if.slave  feat_i,
    neureka_infeat_dbuf_if.master feat_o
);
    localparam int unsigned CNT_W  = $clog2(NW);
    localparam int unsigned LEN_W  = NEUREKA_INFEAT_LEN_W;
    localparam int unsigned WORD_W = BLOCK_SIZE * DW;

    state_infeat_dbuf_t state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic [1:0]         full_q, full_d;

    logic                      run;
    logic                      mask_cur;
    logic                      load_ready;
    logic                      word_we;
    logic                      load_done;
    logic                      rel_fire;
    logic [LEN_W-1:0]          len_last;
    logic [BLOCK_SIZE-1:0][DW-1:0] wdata;
    logic [NW-1:0][WORD_W-1:0] rdata0, rdata1;

    // Handshakes and releases are blocked while frozen or clearing so no input is lost.
    assign run        = enable_i & ~clear_i;
    assign mask_cur   = ctrl_i.load_mask[cnt_q];
    assign len_last   = infeat_eff_len(ctrl_i.load_len) - LEN_W'(1);
    assign load_ready = run & (state_q == LD_ACTIVE) & mask_cur;
    assign word_we    = run & (state_q == LD_ACTIVE) & (~mask_cur | (feat_i.valid[0] & load_ready));
    assign load_done  = word_we & (LEN_W'(cnt_q) == len_last);
    assign rel_fire   = run & ctrl_i.release_bank & full_q[rd_bank_q];

    assign feat_i.ready = {BLOCK_SIZE{load_ready}};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;

        unique case (state_q)
            LD_IDLE:   if (ctrl_i.goto_load) state_d = full_q[wr_bank_q] ? LD_WAIT : LD_ACTIVE;
            LD_WAIT:   if (!full_q[wr_bank_q]) state_d = LD_ACTIVE;
            LD_ACTIVE: if (load_done) state_d = LD_IDLE;
            default:   state_d = LD_IDLE;
        endcase

        if (word_we) cnt_d = cnt_q + CNT_W'(1);
        // Release clears first so a same-cycle completion into the other bank keeps its own bit.
        if (rel_fire) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
        if (load_done) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            cnt_d             = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= LD_IDLE;
            cnt_q     <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
        end else if (clear_i) begin
            state_q   <= LD_IDLE;
            cnt_q     <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
        end else if (enable_i) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
        end
    end

    for (genvar i = 0; i < BLOCK_SIZE; i++) begin : gen_lane
        logic [DW-1:0] lane_data;
        assign lane_data = ctrl_i.feat_broadcast ? feat_i.data[0] : feat_i.data[i];
`ifdef NEUREKA_INFEAT_DBUF_PADDING_EN
        logic [DW-1:0] pad_value;
        assign pad_value = (i % 2 == 0) ? ctrl_i.pad_value_lo : ctrl_i.pad_value_hi;
        assign wdata[i]  = ctrl_i.pad_implicit[cnt_q] ? '0        :
                           ctrl_i.pad_explicit[cnt_q] ? pad_value :
                           mask_cur                   ? lane_data : '0;
`else
        assign wdata[i]  = mask_cur ? lane_data : '0;
`endif
    end

`ifndef NEUREKA_INFEAT_DBUF_PADDING_EN
    logic unused_pad;
    assign unused_pad = ^{ctrl_i.pad_implicit, ctrl_i.pad_explicit,
                          ctrl_i.pad_value_lo, ctrl_i.pad_value_hi};
`endif
    logic unused_stream;
    assign unused_stream = ^{feat_i.valid, feat_i.strb, feat_o.ready};

    neureka_infeat_dbuf_bank #(.NW(NW), .WIDTH(WORD_W)) i_bank0 (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .test_mode (test_mode_i),
        .we        (word_we & ~wr_bank_q),
        .waddr     (cnt_q),
        .wdata     (wdata),
        .rdata     (rdata0)
    );

    neureka_infeat_dbuf_bank #(.NW(NW), .WIDTH(WORD_W)) i_bank1 (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .test_mode (test_mode_i),
        .we        (word_we & wr_bank_q),
        .waddr     (cnt_q),
        .wdata     (wdata),
        .rdata     (rdata1)
    );

    assign feat_o.valid = {(NW * BLOCK_SIZE){full_q[rd_bank_q]}};
    assign feat_o.data  = rd_bank_q ? rdata1 : rdata0;
    assign feat_o.strb  = '1;

    assign flags_o.ld_state  = state_q;
    assign flags_o.bank_full = full_q;
    assign flags_o.wr_bank   = wr_bank_q;
    assign flags_o.rd_bank   = rd_bank_q;
    assign flags_o.vlen_cnt  = cnt_q;
endmodule

// File: tb/tb_neureka_infeat_dbuf.sv
// Directed bench for neureka_infeat_dbuf: table of load scenarios plus hand-written handover sequences.
module tb_neureka_infeat_dbuf;
    import neureka_package::*;

    localparam int unsigned BS = 4;
    localparam int unsigned NW = 64;
    localparam int unsigned TMO = 300;

    logic clk = 1'b0;
    logic rst_n, test_mode, enable, clear;
    ctrl_infeat_dbuf_t  ctrl;
    flags_infeat_dbuf_t flags;
    int unsigned tests = 0;
    int unsigned fails = 0;

    neureka_infeat_dbuf_if #(.N(BS), .DW(8))      feat_in();
    neureka_infeat_dbuf_if #(.N(NW * BS), .DW(8)) feat_out();

    neureka_infeat_dbuf #(.BLOCK_SIZE(BS), .NW(NW), .DW(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .test_mode_i (test_mode),
        .enable_i    (enable),
        .clear_i     (clear),
        .ctrl_i      (ctrl),
        .flags_o     (flags),
        .feat_i      (feat_in),
        .feat_o      (feat_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

    typedef struct {
        logic [6:0]  len;
        logic [63:0] mask;
        logic        bc;
        logic [7:0]  seed;
        int unsigned exp_hs;
        int unsigned exp_cyc;
        int unsigned n_words;
    } vec_t;
    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] rd(input int unsigned w, input int unsigned l);
        return feat_out.data[w * BS + l];
    endfunction

    function automatic logic [7:0] exp_lane(input logic [63:0] mask, input logic bc,
                                            input logic [7:0] seed, input int unsigned w,
                                            input int unsigned l);
        int unsigned k = 0;
        for (int unsigned j = 0; j < w; j++) k += 32'(mask[j]);
        if (!mask[w]) return 8'h00;
        return seed + 8'(k * BS) + (bc ? 8'h00 : 8'(l));
    endfunction

    task automatic set_data(input logic [7:0] base);
        for (int unsigned l = 0; l < BS; l++) feat_in.data[l] = base + 8'(l);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic start(input logic [6:0] len, input logic [63:0] mask, input logic bc);
        ctrl.load_len       = len;
        ctrl.load_mask      = mask;
        ctrl.feat_broadcast = bc;
        ctrl.goto_load      = 1'b1;
        step();
        ctrl.goto_load      = 1'b0;
    endtask

    // Stream words until the loader returns to idle; lane data is seed + handshake*BS + lane.
    task automatic feed(input logic [7:0] seed, output int unsigned hs, output int unsigned cyc);
        hs  = 0;
        cyc = 0;
        feat_in.valid = '1;
        while (flags.ld_state != LD_IDLE && cyc < TMO) begin
            set_data(seed + 8'(hs * BS));
            if (feat_in.ready[0]) hs++;
            step();
            cyc++;
        end
        feat_in.valid = '0;
        if (cyc >= TMO) chk("load_timeout", 64'(cyc), 64'd0);
    endtask

    initial begin
        int unsigned hs, cyc, bad;

        vecs[0] = '{7'd64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8'h00, 64, 64, 64};
        vecs[1] = '{7'd8,  64'h5555_5555_5555_5555, 1'b0, 8'h40,  4,  8,  8};
        vecs[2] = '{7'd0,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8'h90, 64, 64, 64};
        vecs[3] = '{7'd1,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8'hA0,  1,  1,  1};
        vecs[4] = '{7'd5,  64'h0,                   1'b0, 8'h33,  0,  5,  5};
        vecs[5] = '{7'd4,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 8'h70,  4,  4,  4};

        rst_n = 1'b0;
        test_mode = 1'b0;
        enable = 1'b1;
        clear = 1'b0;
        ctrl = '0;
        feat_in.valid = '0;
        feat_in.data = '0;
        feat_in.strb = '1;
        feat_out.ready = '1;

        #1;
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_ready", 64'(feat_in.ready), 64'd0);
        chk("rst_valid", 64'(|feat_out.valid), 64'd0);
        chk("rst_storage", 64'(rd(0, 0)), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        for (int unsigned r = 0; r < 6; r++) begin
            do_clear();
            chk("clr_flags", 64'(flags), 64'd0);
            start(vecs[r].len, vecs[r].mask, vecs[r].bc);
            feed(vecs[r].seed, hs, cyc);
            chk("handshakes", 64'(hs), 64'(vecs[r].exp_hs));
            chk("load_cycles", 64'(cyc), 64'(vecs[r].exp_cyc));
            chk("bank_full", 64'(flags.bank_full), 64'd1);
            chk("wr_bank", 64'(flags.wr_bank), 64'd1);
            chk("vlen_cnt", 64'(flags.vlen_cnt), 64'd0);
            chk("valid_all", 64'(&feat_out.valid), 64'd1);
            bad = 0;
            for (int unsigned w = 0; w < vecs[r].n_words; w++)
                for (int unsigned l = 0; l < BS; l++)
                    if (rd(w, l) !== exp_lane(vecs[r].mask, vecs[r].bc, vecs[r].seed, w, l)) bad++;
            chk("data_words", 64'(bad), 64'd0);
        end

        // Second load into bank1 while bank0 is held, then hand over.
        do_clear();
        start(7'd4, '1, 1'b0);
        feed(8'h10, hs, cyc);
        start(7'd4, '1, 1'b0);
        feed(8'h80, hs, cyc);
        chk("hold_full", 64'(flags.bank_full), 64'd3);
        chk("hold_data", 64'(rd(1, 1)), 64'h15);
        ctrl.release_bank = 1'b1;
        step();
        ctrl.release_bank = 1'b0;
        chk("rel_rd_bank", 64'(flags.rd_bank), 64'd1);
        chk("rel_full", 64'(flags.bank_full), 64'd2);
        chk("rel_valid", 64'(feat_out.valid[0]), 64'd1);
        chk("rel_data", 64'(rd(0, 0)), 64'h80);

        // Both banks full: goto_load waits, resumes after the release.
        start(7'd2, '1, 1'b0);
        feed(8'h20, hs, cyc);
        chk("both_full", 64'(flags.bank_full), 64'd3);
        start(7'd2, '1, 1'b0);
        chk("wait_state", 64'(flags.ld_state), 64'(LD_WAIT));
        chk("wait_ready", 64'(feat_in.ready), 64'd0);
        ctrl.release_bank = 1'b1;
        step();
        ctrl.release_bank = 1'b0;
        chk("wait_after_rel", 64'(flags.ld_state), 64'(LD_WAIT));
        chk("wait_rel_full", 64'(flags.bank_full), 64'd1);
        step();
        chk("resume_state", 64'(flags.ld_state), 64'(LD_ACTIVE));
        chk("resume_ready", 64'(feat_in.ready), 64'hF);

        // Completion and release in the same cycle: valid must not drop.
        feat_in.valid = '1;
        set_data(8'hC0);
        step();
        set_data(8'hC4);
        ctrl.release_bank = 1'b1;
        chk("pre_valid", 64'(feat_out.valid[0]), 64'd1);
        step();
        ctrl.release_bank = 1'b0;
        feat_in.valid = '0;
        chk("swap_full", 64'(flags.bank_full), 64'd2);
        chk("swap_rd_bank", 64'(flags.rd_bank), 64'd1);
        chk("swap_wr_bank", 64'(flags.wr_bank), 64'd0);
        chk("swap_state", 64'(flags.ld_state), 64'(LD_IDLE));
        chk("swap_valid", 64'(feat_out.valid[0]), 64'd1);
        chk("swap_data", 64'(rd(1, 0)), 64'hC4);

        // enable low freezes the loader.
        do_clear();
        start(7'd8, '1, 1'b0);
        feat_in.valid = '1;
        step();
        enable = 1'b0;
        step();
        step();
        chk("frz_cnt", 64'(flags.vlen_cnt), 64'd1);
        chk("frz_ready", 64'(feat_in.ready), 64'd0);
        enable = 1'b1;
        step();
        chk("unfrz_cnt", 64'(flags.vlen_cnt), 64'd2);

        // Clear in the middle of a load.
        do_clear();
        start(7'd64, '1, 1'b0);
        feat_in.valid = '1;
        for (int unsigned i = 0; i < 20 && flags.vlen_cnt != 6'd10; i++) step();
        chk("mid_cnt", 64'(flags.vlen_cnt), 64'd10);
        clear = 1'b1;
        step();
        clear = 1'b0;
        feat_in.valid = '0;
        chk("mid_clr_flags", 64'(flags), 64'd0);
        chk("mid_clr_ready", 64'(feat_in.ready), 64'd0);

        // Padding selects on word 3.
        ctrl.pad_explicit = 64'h8;
        ctrl.pad_value_lo = 8'h11;
        ctrl.pad_value_hi = 8'h22;
        start(7'd4, '1, 1'b0);
        feed(8'h50, hs, cyc);
        chk("pad_hs", 64'(hs), 64'd4);
        chk("pad_w2", 64'(rd(2, 1)), 64'h59);
`ifdef NEUREKA_INFEAT_DBUF_PADDING_EN
        chk("pad_exp_lo", 64'(rd(3, 2)), 64'h11);
        chk("pad_exp_hi", 64'(rd(3, 3)), 64'h22);
`else
        chk("pad_exp_lo", 64'(rd(3, 2)), 64'h5E);
        chk("pad_exp_hi", 64'(rd(3, 3)), 64'h5F);
`endif
        do_clear();
        ctrl.pad_implicit = 64'h8;
        start(7'd4, '1, 1'b0);
        feed(8'h50, hs, cyc);
`ifdef NEUREKA_INFEAT_DBUF_PADDING_EN
        chk("pad_imp_lo", 64'(rd(3, 0)), 64'h00);
        chk("pad_imp_hi", 64'(rd(3, 1)), 64'h00);
`else
        chk("pad_imp_lo", 64'(rd(3, 0)), 64'h5C);
        chk("pad_imp_hi", 64'(rd(3, 1)), 64'h5D);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
